mem_bus_arbiter: RTL
====================

Name: mem_bus_arbiter

Overview:
- Two-master arbiter sharing the single-ported RAM model between the PicoRV32 native memory bus (master 0) and a secondary requester such as a program loader or DMA (master 1).
- Sits between the masters and ram_model.
- Arbitrates, latches the winning request, drives one transaction at a time to the slave, and routes ready/rdata back.
- Includes a watchdog that aborts transactions the slave never acknowledges.

Parameters:
ADDR_WIDTH, 32, address width on master and slave sides
DATA_WIDTH, 32, data width; strobe width = DATA_WIDTH/8
FIXED_PRIO, 0, 0 = round-robin between masters; 1 = master 0 always wins ties
TIMEOUT_CYCLES, 255, max cycles in BUSY waiting for s_ready before abort; 0 disables watchdog
ERR_RDATA, 32'hDEADBEEF, rdata returned on an aborted transaction

Ports:
clk  in  1  system clock, all logic on rising edge
resetn  in  1  synchronous active-low reset
m0_valid  in  1  master 0 request; held until m0_ready
m0_addr  in  ADDR_WIDTH  master 0 byte address
m0_wdata  in  DATA_WIDTH  master 0 write data
m0_wstrb  in  DATA_WIDTH/8  master 0 byte strobes; 0 = read
m0_rdata  out  DATA_WIDTH  master 0 read data, valid when m0_ready=1
m0_ready  out  1  one-cycle completion pulse to master 0
m1_valid, m1_addr, m1_wdata, m1_wstrb, m1_rdata, m1_ready: same as m0_*, for master 1
s_valid  out  1  request to slave
s_addr  out  ADDR_WIDTH  latched address of granted master
s_wdata  out  DATA_WIDTH  latched write data
s_wstrb  out  DATA_WIDTH/8  latched strobes
s_rdata  in  DATA_WIDTH  slave read data
s_ready  in  1  slave completion
grant  out  2  one-hot current owner (bit0 = m0, bit1 = m1); 00 when idle
timeout_err  out  1  sticky; set on any watchdog abort, cleared only by reset

Behaviour:
- Reset (resetn=0 at a rising edge):
  - state=IDLE; s_valid=0; s_addr/s_wdata/s_wstrb=0; grant=00; m0_ready=m1_ready=0; timeout_err=0; watchdog count=0.
  - last_grant=1, so master 0 wins the first tie.
  - Reset mid-transaction drops the transaction silently: no ready pulse to either master.
- States: IDLE, BUSY.
- IDLE:
  - Sample m0_valid/m1_valid. If neither is set, stay in IDLE.
  - If only one is set, grant it.
  - If both are set:
    - FIXED_PRIO=1: grant m0.
    - FIXED_PRIO=0: grant the master != last_grant.
  - On grant, at the same edge: latch winner's addr/wdata/wstrb into s_*; set grant; s_valid<=1; watchdog<=0; go to BUSY.
- BUSY:
  - s_valid=1 and s_* held stable; master inputs are ignored, including changes to the granted master's own fields.
  - On s_ready=1, in the same cycle (combinational):
    - granted mN_ready=1.
    - mN_rdata=s_rdata.
  - At that edge: s_valid<=0; grant<=00; last_grant<=winner; go to IDLE.
- Latency:
  - Request seen at edge N → s_valid from N+1.
  - Zero-wait slave (s_ready in the first BUSY cycle) completes in 2 cycles from valid.
  - Minimum 1 idle cycle between transactions; back-to-back throughput is 1 transaction per 2 cycles with a zero-wait slave.
- Non-granted master: ready=0 and rdata=0 at all times.
- Watchdog:
  - Counts each BUSY cycle with s_ready=0.
  - When the count reaches TIMEOUT_CYCLES (TIMEOUT_CYCLES>0), the next cycle is an abort cycle: s_valid=0 (combinational), granted mN_ready=1, mN_rdata=ERR_RDATA.
  - At the abort edge: timeout_err<=1; go to IDLE; last_grant<=winner.
  - If s_ready arrives in that same cycle, s_ready wins: normal completion, no error.
- A master dropping valid during BUSY is a protocol violation: the transaction still completes and the ready pulse is still issued.
- Strobes pass through unmodified; address is not decoded or aligned here.

Test Plan:
- Single read: m0_valid=1, addr=0x10, wstrb=0; slave returns s_ready at the first BUSY cycle with s_rdata=0x12345678 → s_valid high 1 cycle, s_addr=0x10, m0_ready pulse with m0_rdata=0x12345678 two cycles after request; grant=01 then 00.
- Tie, round-robin: after reset, m0 and m1 both hold valid continuously → grants alternate 01,10,01,10; m1_ready never asserts while grant=01.
- Tie with FIXED_PRIO=1 and m0 continuously valid → m1 never granted; m1_ready stays 0 for 20 transactions.
- Write latch: m1 write addr=0x200, wdata=0xA5A5A5A5, wstrb=4'b0011; m1 changes addr after grant; slave ready after 3 cycles → s_addr/s_wdata/s_wstrb stay at the latched values for all BUSY cycles.
- Timeout: TIMEOUT_CYCLES=4, slave never readies → m0_ready pulses with m0_rdata=0xDEADBEEF after 4 stalled BUSY cycles; timeout_err=1 and remains set; the next request proceeds normally.
- Reset mid-transaction: resetn=0 for one edge while BUSY → s_valid=0, grant=00, no ready pulse; first post-reset tie goes to m0.

Source files
------------

// File: rtl/mem_bus_arbiter.sv
// Two-master arbiter in front of a single-ported RAM model.
// Master 0 is the CPU native bus, master 1 a loader/DMA. One transaction
// is in flight at a time; a watchdog aborts requests the slave never acks.
module mem_bus_arbiter #(
    parameter int unsigned ADDR_WIDTH     = 32,
    parameter int unsigned DATA_WIDTH     = 32,
    parameter int unsigned FIXED_PRIO     = 0,
    parameter int unsigned TIMEOUT_CYCLES = 255,
    parameter logic [DATA_WIDTH-1:0] ERR_RDATA = DATA_WIDTH'(32'hDEADBEEF)
) (
    input  logic                      clk,
    input  logic                      resetn,

    input  logic                      m0_valid,
    input  logic [ADDR_WIDTH-1:0]     m0_addr,
    input  logic [DATA_WIDTH-1:0]     m0_wdata,
    input  logic [DATA_WIDTH/8-1:0]   m0_wstrb,
    output logic [DATA_WIDTH-1:0]     m0_rdata,
    output logic                      m0_ready,

    input  logic                      m1_valid,
    input  logic [ADDR_WIDTH-1:0]     m1_addr,
    input  logic [DATA_WIDTH-1:0]     m1_wdata,
    input  logic [DATA_WIDTH/8-1:0]   m1_wstrb,
    output logic [DATA_WIDTH-1:0]     m1_rdata,
    output logic                      m1_ready,

    output logic                      s_valid,
    output logic [ADDR_WIDTH-1:0]     s_addr,
    output logic [DATA_WIDTH-1:0]     s_wdata,
    output logic [DATA_WIDTH/8-1:0]   s_wstrb,
    input  logic [DATA_WIDTH-1:0]     s_rdata,
    input  logic                      s_ready,

    output logic [1:0]                grant,
    output logic                      timeout_err
);

    localparam int unsigned STRB_WIDTH = DATA_WIDTH / 8;
    localparam int unsigned CNT_WIDTH  = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
    localparam logic [CNT_WIDTH-1:0] CNT_MAX = CNT_WIDTH'(TIMEOUT_CYCLES);
    localparam bit   WDOG_EN     = (TIMEOUT_CYCLES != 0);
    localparam bit   ROUND_ROBIN = (FIXED_PRIO == 0);

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_BUSY = 1'b1
    } state_t;

    state_t                  state_q,       state_d;
    logic                    s_valid_q,     s_valid_d;
    logic [ADDR_WIDTH-1:0]   s_addr_q,      s_addr_d;
    logic [DATA_WIDTH-1:0]   s_wdata_q,     s_wdata_d;
    logic [STRB_WIDTH-1:0]   s_wstrb_q,     s_wstrb_d;
    logic [1:0]              grant_q,       grant_d;
    logic                    last_grant_q,  last_grant_d;   // 1 = master 1 won last
    logic [CNT_WIDTH-1:0]    wdog_q,        wdog_d;
    logic                    timeout_err_q, timeout_err_d;

    logic                    pick_m1_c;
    logic                    abort_c;
    logic                    done_c;
    logic [DATA_WIDTH-1:0]   rsp_data_c;

    // Abort fires once the stall count has reached the limit; a late s_ready still wins
    assign abort_c    = WDOG_EN && (state_q == ST_BUSY) && !s_ready && (wdog_q == CNT_MAX);
    assign done_c     = (state_q == ST_BUSY) && (s_ready || abort_c);
    assign rsp_data_c = s_ready ? s_rdata : ERR_RDATA;

    // State and latched-request registers
    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_q       <= ST_IDLE;
            s_valid_q     <= 1'b0;
            s_addr_q      <= '0;
            s_wdata_q     <= '0;
            s_wstrb_q     <= '0;
            grant_q       <= 2'b00;
            last_grant_q  <= 1'b1;
            wdog_q        <= '0;
            timeout_err_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            s_valid_q     <= s_valid_d;
            s_addr_q      <= s_addr_d;
            s_wdata_q     <= s_wdata_d;
            s_wstrb_q     <= s_wstrb_d;
            grant_q       <= grant_d;
            last_grant_q  <= last_grant_d;
            wdog_q        <= wdog_d;
            timeout_err_q <= timeout_err_d;
        end
    end

    // Arbitration, request latching, completion and watchdog
    always_comb begin
        state_d       = state_q;
        s_valid_d     = s_valid_q;
        s_addr_d      = s_addr_q;
        s_wdata_d     = s_wdata_q;
        s_wstrb_d     = s_wstrb_q;
        grant_d       = grant_q;
        last_grant_d  = last_grant_q;
        wdog_d        = wdog_q;
        timeout_err_d = timeout_err_q;
        pick_m1_c     = m1_valid && (!m0_valid || (ROUND_ROBIN && !last_grant_q));

        case (state_q)
            ST_IDLE: begin
                if (m0_valid || m1_valid) begin
                    s_addr_d  = pick_m1_c ? m1_addr  : m0_addr;
                    s_wdata_d = pick_m1_c ? m1_wdata : m0_wdata;
                    s_wstrb_d = pick_m1_c ? m1_wstrb : m0_wstrb;
                    grant_d   = pick_m1_c ? 2'b10 : 2'b01;
                    s_valid_d = 1'b1;
                    wdog_d    = '0;
                    state_d   = ST_BUSY;
                end
            end
            ST_BUSY: begin
                if (done_c) begin
                    s_valid_d    = 1'b0;
                    grant_d      = 2'b00;
                    last_grant_d = grant_q[1];
                    state_d      = ST_IDLE;
                    if (abort_c) begin
                        timeout_err_d = 1'b1;
                    end
                end else if (WDOG_EN && (wdog_q != CNT_MAX)) begin
                    wdog_d = wdog_q + CNT_WIDTH'(1);
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Slave side: request is withdrawn combinationally in the abort cycle
    assign s_valid     = s_valid_q && !abort_c;
    assign s_addr      = s_addr_q;
    assign s_wdata     = s_wdata_q;
    assign s_wstrb     = s_wstrb_q;
    assign grant       = grant_q;
    assign timeout_err = timeout_err_q;

    // Completion is routed only to the owner; everyone else sees zeros
    assign m0_ready = done_c && grant_q[0];
    assign m1_ready = done_c && grant_q[1];
    assign m0_rdata = m0_ready ? rsp_data_c : '0;
    assign m1_rdata = m1_ready ? rsp_data_c : '0;

endmodule
